// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer with BCD MM:SS count and per-field blink blanking
module stopwatch_ctrl #(
    parameter bit BLINK = 1'b1
) (
    input  logic       clkDis,
    input  logic       rst,
    input  logic       tick1Hz,
    input  logic       tick2Hz,
    input  logic       pausePulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] minT,
    output logic [3:0] minO,
    output logic [3:0] secT,
    output logic [3:0] secO,
    output logic       running,
    output logic       adjusting,
    output logic       blankMin,
    output logic       blankSec
);
    typedef enum logic [1:0] {RUN, PAUSED, ADJ} state_t;

    state_t     state_q, state_d;
    logic       run_q, run_d, phase_q, phase_d;
    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic       cnt_run, adj_tick, sec_step, min_step;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            RUN: begin
                run_d   = run_q & ~pausePulse;
                state_d = adj ? ADJ : pausePulse ? PAUSED : RUN;
            end
            PAUSED: begin
                run_d   = run_q | pausePulse;
                state_d = adj ? ADJ : pausePulse ? RUN : PAUSED;
            end
            ADJ: begin
                run_d   = run_q ^ pausePulse;
                state_d = adj ? ADJ : run_q ? RUN : PAUSED;
            end
            default: state_d = RUN;
        endcase
    end

    // Seconds wrap only carries into minutes while running; ADJ steps one field in isolation.
    assign cnt_run  = (state_q == RUN) & tick1Hz;
    assign adj_tick = (state_q == ADJ) & tick2Hz;
    assign sec_step = cnt_run | (adj_tick & sel);
    assign min_step = (cnt_run & so_q == 4'd9 & st_q == 4'd5) | (adj_tick & ~sel);

    assign so_d = sec_step ? (so_q == 4'd9 ? 4'd0 : so_q + 4'd1) : so_q;
    assign st_d = (sec_step & so_q == 4'd9) ? (st_q == 4'd5 ? 4'd0 : st_q + 4'd1) : st_q;
    assign mo_d = min_step ? (mo_q == 4'd9 ? 4'd0 : mo_q + 4'd1) : mo_q;
    assign mt_d = (min_step & mo_q == 4'd9) ? (mt_q == 4'd9 ? 4'd0 : mt_q + 4'd1) : mt_q;

    assign phase_d = (state_q == ADJ && state_d == ADJ) ? phase_q ^ tick2Hz : 1'b0;

    always_ff @(posedge clkDis) begin
        if (rst) begin
            state_q <= RUN;
            run_q   <= 1'b1;
            phase_q <= 1'b0;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            phase_q <= phase_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
        end
    end

    assign minT      = mt_q;
    assign minO      = mo_q;
    assign secT      = st_q;
    assign secO      = so_q;
    assign running   = (state_q == RUN);
    assign adjusting = (state_q == ADJ);
    assign blankMin  = BLINK & adjusting & ~sel & phase_q;
    assign blankSec  = BLINK & adjusting & sel & phase_q;
endmodule
